// File: rtl/fifo_axis_reader_if.sv
`default_nettype none
// =============================================================================
// Module   : fifo_axis_reader_if
// Brief    : Native FIFO read port plus AXI-Stream master bundle.
// Revision : 1.0
// =============================================================================
interface fifo_axis_reader_if #(
    parameter int DWIDTH = 32
);
    logic              fifo_rd_en;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic [DWIDTH-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [1:0]        buf_level;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output buf_level
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  buf_level
    );
endinterface
`default_nettype wire

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// =============================================================================
// Module   : fifo_axis_reader
// Brief    : Latency-1 native FIFO read port to AXI-Stream master, 3-entry skid.
// Revision : 1.0
// =============================================================================
module fifo_axis_reader #(
    parameter int DWIDTH    = 32,
    parameter int BUF_DEPTH = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fifo_axis_reader_if.master bus
);

    generate
        if (BUF_DEPTH != 3) begin : g_depth_check
            $error("fifo_axis_reader: BUF_DEPTH must be 3");
        end
        if (DWIDTH < 1 || DWIDTH > 1024) begin : g_width_check
            $error("fifo_axis_reader: DWIDTH must be in 1..1024");
        end
    endgenerate

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0]        rst_sync_q;
    logic              run;

    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [1:0]        head_q,     head_d;
    logic [1:0]        tail_q,     tail_d;
    logic [1:0]        level_q,    level_d;
    logic              inflight_q, inflight_d;
    logic              tvalid_q,   tvalid_d;
    logic [DWIDTH-1:0] tdata_q,    tdata_d;

    logic              push;
    logic              pop;
    logic              rd_en;
    logic [2:0]        occupancy;

    // Async assert, clock-synchronous release of the internal run enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_comb begin
        occupancy  = {1'b0, level_q} + {2'b00, inflight_q};
        push       = inflight_q;
        pop        = tvalid_q & bus.m_axis_tready;
        rd_en      = run & ~bus.fifo_rd_empty & (occupancy < 3'd3);
        inflight_d = rd_en;

        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase
        tvalid_d = (level_d != 2'd0);

        // The arriving word bypasses the array when it lands on the next head.
        if (push && (tail_q == head_d)) begin
            tdata_d = bus.fifo_rd_data;
        end else begin
            tdata_d = mem_q[head_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= bus.fifo_rd_data;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
        end
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.buf_level     = level_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (occupancy <= 3'd3)
                else $error("fifo_axis_reader: buffer overflow, level+inflight=%0d", occupancy);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_axis_reader.md
FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 The block SHALL take parameter DWIDTH, default 32: data width in bits, legal range 1..1024.
REQ-002 The block SHALL take parameter BUF_DEPTH, default 3: output buffer entries, fixed at 3, any other value a elaboration error.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_rd_en  output  1  read strobe to the native sync FIFO read port.
REQ-006 fifo_rd_data  input  DWIDTH  FIFO read data, valid exactly one cycle after an accepted fifo_rd_en.
REQ-007 fifo_rd_empty  input  1  FIFO empty flag; a read is accepted only when fifo_rd_en=1 and fifo_rd_empty=0 in the same cycle.
REQ-008 m_axis_tdata  output  DWIDTH  AXI-Stream master data.
REQ-009 m_axis_tvalid  output  1  AXI-Stream master valid.
REQ-010 m_axis_tready  input  1  AXI-Stream slave ready.
REQ-011 buf_level  output  2  current buffer occupancy, 0..3.

Function
REQ-012 The block SHALL convert the native, latency-1 FIFO read port into an AXI-Stream master with no data loss, no duplication and in-order delivery.
REQ-013 inflight SHALL be a 1-bit register set to 1 in the cycle after an accepted read and cleared otherwise.
REQ-014 fifo_rd_en SHALL be ~fifo_rd_empty AND (buf_level + inflight) < 3, a function of registered state and fifo_rd_empty only, with no combinational path from m_axis_tready.
REQ-015 When inflight=1, fifo_rd_data SHALL be written into the buffer tail on that posedge.
REQ-016 m_axis_tvalid SHALL be (buf_level != 0), and m_axis_tdata SHALL be the head entry, both driven from registers.
REQ-017 A pop SHALL occur when m_axis_tvalid=1 and m_axis_tready=1, and the head SHALL advance on that posedge.
REQ-018 A simultaneous push and pop SHALL leave buf_level unchanged and preserve order, including at buf_level=1, where the arriving word becomes the head on the next cycle.
REQ-019 Once m_axis_tvalid is asserted, m_axis_tvalid and m_axis_tdata SHALL hold stable until the pop, per AXI-Stream.
REQ-020 Overflow SHALL be impossible by construction (buf_level + inflight <= 3 at all times), and an assertion SHALL flag any violation.
REQ-021 Head and tail pointers SHALL wrap modulo 3, with 2 followed by 0.
REQ-022 Throughput: with the FIFO non-empty and m_axis_tready held at 1, the block SHALL deliver one beat per cycle in steady state.
REQ-023 First-word latency: from fifo_rd_empty falling with an idle, empty block to m_axis_tvalid rising SHALL be exactly 2 cycles (read, then capture).
REQ-024 When m_axis_tready=0 indefinitely, the block SHALL stop reading with buf_level=3 and inflight=0, and no FIFO word SHALL be lost.
REQ-025 A rising fifo_rd_empty while inflight=1 SHALL still capture the in-flight word.

Reset
REQ-026 Asserting rst_n=0 SHALL asynchronously clear buf_level, inflight, the head and tail pointers, fifo_rd_en, m_axis_tvalid (to 0) and m_axis_tdata (to all zeros).
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; the words the FIFO already supplied are not recovered.
REQ-028 Deassertion of rst_n SHALL be synchronised to clk internally, and the first fifo_rd_en SHALL occur no earlier than 2 cycles after rst_n rises.

Verification
REQ-029 Reset: rst_n=0 with random inputs -> fifo_rd_en=0, m_axis_tvalid=0, m_axis_tdata=0, buf_level=0 without a clock edge.
REQ-030 Streaming: FIFO preloaded with 0x1..0x10 and tready=1 -> the 16 beats emerge in order, back-to-back after a first-word latency of 2 cycles.
REQ-031 Backpressure: 8 words and tready=0 -> buf_level reaches 3, fifo_rd_en drops, and 3 reads in total are made; then tready=1 -> 0x1..0x8 arrive in order with none lost.
REQ-032 Random tready (50%) with 1000 random words against a scoreboard -> exact in-order match, and tdata/tvalid stable while stalled.
REQ-033 Empty edge: a single word 0xA5 with fifo_rd_empty rising in the read cycle -> exactly one beat of 0xA5 and no extra read.
REQ-034 Mid-stream reset: reset asserted while buf_level=2 -> outputs clear immediately, and after release a new stream of 0x100.. is delivered correctly.
